// File: rtl/countdown_from_6.sv
// rtl/countdown_from_6.sv - mod-(MAX+1) down-counter with load, start/pause, prescaler and terminal pulse
module countdown_from_6 #(
    parameter int WIDTH       = 4,
    parameter int MAX         = 6,
    parameter int DIV         = 1,
    parameter bit AUTO_RELOAD = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             tick_en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PMAX = PW'(DIV - 1);
    localparam logic [PW-1:0]    PONE = PW'(1);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= MAXV;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (load) begin
            count_d = (load_val > MAXV) ? MAXV : load_val;
            presc_d = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        presc_d = '0;
                        if (count_q == '0 && !AUTO_RELOAD)
                            state_d = DONE;
                        else
                            state_d = RUN;
                    end
                end
                RUN: begin
                    // pause takes the cycle; any step due now is dropped
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick_en) begin
                        if (presc_q == PMAX) begin
                            presc_d = '0;
                            if (count_q > ONE) begin
                                count_d = count_q - ONE;
                            end else if (count_q == ONE) begin
                                count_d = '0;
                                done_d  = 1'b1;
                                if (!AUTO_RELOAD)
                                    state_d = DONE;
                            end else if (AUTO_RELOAD) begin
                                count_d = MAXV;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            presc_d = presc_q + PONE;
                        end
                    end
                end
                PAUSED: begin
                    if (start && !pause)
                        state_d = RUN;
                end
                DONE: begin
                    if (start) begin
                        count_d = MAXV;
                        presc_d = '0;
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN) || (state_q == PAUSED);
    assign done  = done_q;

endmodule

// File: tb/tb_countdown_from_6.sv
// tb/tb_countdown_from_6.sv - directed self-checking bench for countdown_from_6
module tb_countdown_from_6;

    logic       clk = 1'b0;
    logic       reset, load, start, pause, tick_en;
    logic [3:0] load_val;
    logic [3:0] count_a, count_b, count_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    // a: DIV=1 auto-reload, b: DIV=1 one-shot, c: DIV=3 auto-reload
    countdown_from_6 #(.WIDTH(4), .MAX(6), .DIV(1), .AUTO_RELOAD(1'b1)) u_a (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start),
        .pause(pause), .tick_en(tick_en), .count(count_a), .busy(busy_a), .done(done_a));
    countdown_from_6 #(.WIDTH(4), .MAX(6), .DIV(1), .AUTO_RELOAD(1'b0)) u_b (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start),
        .pause(pause), .tick_en(tick_en), .count(count_b), .busy(busy_b), .done(done_b));
    countdown_from_6 #(.WIDTH(4), .MAX(6), .DIV(3), .AUTO_RELOAD(1'b1)) u_c (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start),
        .pause(pause), .tick_en(tick_en), .count(count_c), .busy(busy_c), .done(done_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; load = 1'b0; load_val = 4'd0;
        start = 1'b0; pause = 1'b0; tick_en = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; load = 1'b0; load_val = 4'd0;
        start = 1'b0; pause = 1'b0; tick_en = 1'b0;
        #12;
        n_checks++;
        if ({count_a, busy_a, done_a} !== {4'd6, 1'b0, 1'b0}) begin
            $display("FAIL reset_init: count=%0d busy=%b done=%b, want 6 0 0", count_a, busy_a, done_a);
            n_fail++;
        end
        step();
        reset = 1'b1;
        tick_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({count_a, busy_a} !== {4'd3, 1'b1}) begin
            $display("FAIL reset_precount: count=%0d busy=%b, want 3 1", count_a, busy_a);
            n_fail++;
        end
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({count_a, busy_a, done_a} !== {4'd6, 1'b0, 1'b0}) begin
            $display("FAIL reset_async: count=%0d busy=%b done=%b, want 6 0 0", count_a, busy_a, done_a);
            n_fail++;
        end
        #2;
        reset = 1'b1;
    endtask

    task automatic test_wrap();
        logic [3:0] exp_cnt [0:7];
        logic       exp_done [0:7];
        exp_cnt  = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd6, 4'd5};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        tick_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if ({count_a, busy_a, done_a} !== {4'd6, 1'b1, 1'b0}) begin
            $display("FAIL wrap_start: count=%0d busy=%b done=%b, want 6 1 0", count_a, busy_a, done_a);
            n_fail++;
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if ({count_a, done_a} !== {exp_cnt[i], exp_done[i]}) begin
                $display("FAIL wrap_seq[%0d]: count=%0d done=%b, want %0d %b",
                         i, count_a, done_a, exp_cnt[i], exp_done[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_done_state();
        do_reset();
        tick_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            n_checks++;
            if ({count_b, done_b, busy_b} !== {4'(6 - i), (i == 6), (i != 6)}) begin
                $display("FAIL oneshot_seq[%0d]: count=%0d done=%b busy=%b, want %0d %b %b",
                         i, count_b, done_b, busy_b, 6 - i, (i == 6), (i != 6));
                n_fail++;
            end
        end
        repeat (2) begin
            step();
            n_checks++;
            if ({count_b, done_b, busy_b} !== {4'd0, 1'b0, 1'b0}) begin
                $display("FAIL oneshot_hold: count=%0d done=%b busy=%b, want 0 0 0", count_b, done_b, busy_b);
                n_fail++;
            end
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if ({count_b, busy_b} !== {4'd6, 1'b1}) begin
            $display("FAIL oneshot_restart: count=%0d busy=%b, want 6 1", count_b, busy_b);
            n_fail++;
        end
        step();
        n_checks++;
        if (count_b !== 4'd5) begin
            $display("FAIL oneshot_rerun: count=%0d, want 5", count_b);
            n_fail++;
        end
    endtask

    task automatic test_pause();
        do_reset();
        tick_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({count_a, busy_a} !== {4'd4, 1'b1}) begin
                $display("FAIL pause_hold[%0d]: count=%0d busy=%b, want 4 1", i, count_a, busy_a);
                n_fail++;
            end
        end
        pause = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (count_a !== 4'd4) begin
            $display("FAIL pause_resume_edge: count=%0d, want 4", count_a);
            n_fail++;
        end
        step();
        n_checks++;
        if (count_a !== 4'd3) begin
            $display("FAIL pause_resume_step: count=%0d, want 3", count_a);
            n_fail++;
        end
        pause = 1'b1; start = 1'b1;
        repeat (2) step();
        pause = 1'b0; start = 1'b0;
        step();
        n_checks++;
        if ({count_a, busy_a} !== {4'd3, 1'b1}) begin
            $display("FAIL pause_start_same: count=%0d busy=%b, want 3 1", count_a, busy_a);
            n_fail++;
        end
    endtask

    task automatic test_load();
        logic [3:0] vals [0:4];
        logic [3:0] exps [0:4];
        vals = '{4'd9, 4'd7, 4'd6, 4'd15, 4'd3};
        exps = '{4'd6, 4'd6, 4'd6, 4'd6,  4'd3};
        do_reset();
        tick_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        load = 1'b1; load_val = 4'd9; start = 1'b1; pause = 1'b1;
        step();
        start = 1'b0; pause = 1'b0;
        n_checks++;
        if ({count_a, busy_a, done_a} !== {4'd6, 1'b0, 1'b0}) begin
            $display("FAIL load_priority: count=%0d busy=%b done=%b, want 6 0 0", count_a, busy_a, done_a);
            n_fail++;
        end
        for (int i = 0; i < 5; i++) begin
            load_val = vals[i];
            step();
            n_checks++;
            if (count_a !== exps[i]) begin
                $display("FAIL load_sat[%0d]: count=%0d, want %0d", i, count_a, exps[i]);
                n_fail++;
            end
        end
        load_val = 4'd2;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if ({count_a, busy_a} !== {4'd2, 1'b1}) begin
            $display("FAIL load_start: count=%0d busy=%b, want 2 1", count_a, busy_a);
            n_fail++;
        end
        step();
        n_checks++;
        if ({count_a, done_a} !== {4'd1, 1'b0}) begin
            $display("FAIL load_run1: count=%0d done=%b, want 1 0", count_a, done_a);
            n_fail++;
        end
        step();
        n_checks++;
        if ({count_a, done_a} !== {4'd0, 1'b1}) begin
            $display("FAIL load_run0: count=%0d done=%b, want 0 1", count_a, done_a);
            n_fail++;
        end
        load = 1'b1; load_val = 4'd0;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if ({busy_a, busy_b, count_b, done_b} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
            $display("FAIL start_from_zero: busy_a=%b busy_b=%b count_b=%0d done_b=%b, want 1 0 0 0",
                     busy_a, busy_b, count_b, done_b);
            n_fail++;
        end
        step();
        n_checks++;
        if ({count_a, done_a} !== {4'd6, 1'b0}) begin
            $display("FAIL zero_wrap: count=%0d done=%b, want 6 0", count_a, done_a);
            n_fail++;
        end
    endtask

    task automatic test_prescale();
        logic       ticks [0:5];
        logic [3:0] exp_c [0:5];
        logic [3:0] exp_a [0:5];
        ticks = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_c = '{4'd6, 4'd6, 4'd6, 4'd5, 4'd5, 4'd5};
        exp_a = '{4'd5, 4'd5, 4'd4, 4'd3, 4'd3, 4'd2};
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick_en = ticks[i];
            step();
            n_checks++;
            if ({count_c, done_c, count_a} !== {exp_c[i], 1'b0, exp_a[i]}) begin
                $display("FAIL prescale[%0d]: count_c=%0d done_c=%b count_a=%0d, want %0d 0 %0d",
                         i, count_c, done_c, count_a, exp_c[i], exp_a[i]);
                n_fail++;
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_wrap();
        test_done_state();
        test_pause();
        test_load();
        test_prescale();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
